// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
// start is a request pulse: it is taken on any rising edge where busy==0 and dropped otherwise.
interface muldiv_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output start, md_op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Fixed-latency MIPS-style mult/multu/div/divu unit owning the HI and LO registers.
// Operands are latched at start; the result is committed once the latency counter expires.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_latch;
  logic        w_commit;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_latch     = 1'b1;
          w_state_nxt = bus.md_op[1] ? DIV : MUL;
          w_cnt_nxt   = bus.md_op[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      MUL, DIV: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_commit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= 32'd0;
      r_b  <= 32'd0;
      r_op <= 2'd0;
    end else if (w_latch) begin
      r_a  <= bus.a;
      r_b  <= bus.b;
      r_op <= bus.md_op;
    end
  end

  // Multiply: extend per signedness, the low 64 bits of the product are exact either way.
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  assign w_ext_a = r_op[0] ? {32'd0, r_a} : {{32{r_a[31]}}, r_a};
  assign w_ext_b = r_op[0] ? {32'd0, r_b} : {{32{r_b[31]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  assign w_neg_a = ~r_op[0] & r_a[31];
  assign w_neg_b = ~r_op[0] & r_b[31];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;
  assign w_den   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag = w_mag_a / w_den;
  assign w_r_mag = w_mag_a % w_den;
  assign w_quot  = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_rem   = w_neg_a ? -w_r_mag : w_r_mag;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_op[1]) begin
      if (r_b == 32'd0) begin
        w_res_hi = r_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
    end
  end

  // mthi/mtlo only land in IDLE and lose to a simultaneous start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == IDLE && !bus.start) begin
      if (bus.mthi) r_hi <= bus.wdata;
      if (bus.mtlo) r_lo <= bus.wdata;
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge before driving.
module tb_muldiv_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Returns {hi, lo} from the architectural definition of each operation.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa;
    int          sb;
    longint      prod;
    logic [31:0] q;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin
        prod = longint'(sa) * longint'(sb);
        return prod;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
    endcase
  endfunction

  // Launch one operation and follow it to its done cycle (returns on the done-cycle falling edge).
  // b2b launches in the current cycle (the previous done cycle); inject_at>0 fires start+mthi mid-op.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input bit mt_with_start, input int inject_at);
    logic [63:0] exp;
    int          n;
    bit          bad;
    if (!b2b) begin
      @(negedge clk);
      chk("done_one_cycle", bus.done, 1'b0);
    end
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = a;
    bus.b     = b;
    if (mt_with_start) begin
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = $urandom;
    end
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.md_op = 2'($urandom_range(0, 3));
    n   = 0;
    bad = 1'b0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) bad = 1'b1;
      n++;
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_AAAA;
      end
      @(negedge clk);
      if (n == inject_at) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
      end
    end
    chk("busy_len", n, op[1] ? DC : MC);
    chk("quiet_during_busy", bad, 1'b0);
    chk("done_pulse", bus.done, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      exp  = exp_q.pop_front();
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  endtask

  task automatic mt_write(input bit wr_hi, input bit wr_lo, input logic [31:0] data);
    @(negedge clk);
    bus.mthi  = wr_hi;
    bus.mtlo  = wr_lo;
    bus.wdata = data;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (wr_hi) m_hi = data;
    if (wr_lo) m_lo = data;
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    bit          saw;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.md_op = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = 32'd0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;

    // Directed arithmetic cases; the second one starts in the done cycle of the first.
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 0);
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    chk("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", bus.lo, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
    chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
    chk("divu_hi_const", bus.hi, 32'h0000_0001);
    chk("divu_lo_const", bus.lo, 32'h7FFF_FFFC);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 0);
    chk("divz_hi_const", bus.hi, 32'h0000_1234);
    chk("divz_lo_const", bus.lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    chk("divovf_hi_const", bus.hi, 32'h0000_0000);
    chk("divovf_lo_const", bus.lo, 32'h8000_0000);

    // start+mthi during a divide is ignored, then mthi+mtlo in IDLE lands.
    run_op(2'b10, 32'd1000, 32'd7, 1'b0, 1'b0, 3);
    mt_write(1'b1, 1'b1, 32'h0000_0055);
    chk("mt55_hi_const", bus.hi, 32'h0000_0055);
    chk("mt55_lo_const", bus.lo, 32'h0000_0055);
    mt_write(1'b0, 1'b1, 32'h1357_9BDF);
    mt_write(1'b1, 1'b0, 32'h2468_ACE0);

    // start together with mthi/mtlo in IDLE: start wins.
    run_op(2'b01, 32'd12345, 32'd678, 1'b0, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      op  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      run_op(op, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, op[1] ? DC : MC) : 0);
    end

    // Reset in the third cycle of a divide: nothing committed, no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'b10;
    bus.a     = 32'd5000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    saw   = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
    end
    chk("no_done_after_rst", saw, 1'b0);
    run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0, 0);
    chk("post_rst_lo", bus.lo, 32'd42);
    chk("post_rst_hi", bus.hi, 32'd0);

    @(negedge clk);
    chk("final_done_low", bus.done, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have the parameter MULT_CYCLES, default 5, giving the multiply latency in clock cycles (allowed range 1..15).
REQ-002 The block SHALL have the parameter DIV_CYCLES, default 10, giving the divide latency in clock cycles (allowed range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request pulse that launches a multiply or divide.
REQ-006 The block SHALL have port md_op, input, 2 bits: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 The block SHALL have port a, input, 32 bits: rs operand (multiplicand or dividend).
REQ-008 The block SHALL have port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-009 The block SHALL have port mthi, input, 1 bit: write wdata to HI.
REQ-010 The block SHALL have port mtlo, input, 1 bit: write wdata to LO.
REQ-011 The block SHALL have port wdata, input, 32 bits: data for mthi/mtlo.
REQ-012 The block SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls mfhi/mflo/mult/div on it.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after results are committed.
REQ-014 The block SHALL have port hi, output, 32 bits: HI register.
REQ-015 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-016 The FSM SHALL have the states IDLE, MUL and DIV, with a 4-bit down-counter cnt.
REQ-017 In IDLE, when start=1 is sampled at rising edge E0, the block SHALL latch a, b and md_op; go to MUL (md_op[1]=0) or DIV (md_op[1]=1); and load cnt with MULT_CYCLES-1 or DIV_CYCLES-1.
REQ-018 In MUL or DIV, cnt SHALL decrement each edge; on the edge where cnt==0, HI/LO SHALL be written, the state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-019 busy SHALL be 1 for exactly MULT_CYCLES (or DIV_CYCLES) cycles after E0, and 0 otherwise; busy and done are never both 1.
REQ-020 mult SHALL give the signed 64-bit product; multu SHALL give the unsigned 64-bit product; in both cases HI = bits 63:32 and LO = bits 31:0.
REQ-021 div SHALL give a signed quotient in LO, truncated toward zero, and the remainder in HI, carrying the dividend's sign; divu SHALL give the unsigned quotient in LO and the remainder in HI.
REQ-022 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-023 A divisor of 0 (div or divu) SHALL give LO=0xFFFFFFFF and HI equal to the latched dividend.
REQ-024 Results SHALL be computed from the latched operands; changes on a, b or md_op after E0 SHALL NOT affect the result.
REQ-025 start while busy=1 SHALL be ignored: no restart and no state change.
REQ-026 In IDLE, mthi=1 SHALL write wdata to HI and mtlo=1 SHALL write wdata to LO at the edge; both may be asserted together.
REQ-027 mthi/mtlo while busy=1 SHALL be ignored.
REQ-028 start together with mthi/mtlo in IDLE: start SHALL win and the mt write SHALL be dropped.
REQ-029 hi and lo SHALL be driven directly from registers and SHALL hold their value between writes; they do not change during busy.
REQ-030 Commit and a new start in the cycle done=1 SHALL be legal: that start is accepted, because the state is IDLE.

Reset
REQ-031 Asserting reset (0) SHALL immediately force state=IDLE, cnt=0, busy=0, done=0, hi=0 and lo=0, including mid-operation, with no partial result written.
REQ-032 After reset deasserts, the first start SHALL be accepted at the first rising edge where it is sampled.

Verification
REQ-033 The bench SHALL cover mult: a=0xFFFFFFFE (-2), b=3, start for one cycle -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, and done pulses once.
REQ-034 The bench SHALL cover multu: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles, hi=0xFFFFFFFE and lo=0x00000001.
REQ-035 The bench SHALL cover div: a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF; the same operands with divu -> lo=0x7FFFFFFC and hi=0x00000001.
REQ-036 The bench SHALL cover divu by zero with a=0x1234 -> lo=0xFFFFFFFF and hi=0x00001234; it SHALL also cover div 0x80000000 / -1 -> lo=0x80000000 and hi=0.
REQ-037 The bench SHALL cover these while busy: start plus mthi with wdata=0xAAAA during a divide -> ignored, the divide result is unchanged and busy is not extended; then mthi+mtlo in IDLE with wdata=0x55 -> hi=lo=0x55 next cycle.
REQ-038 The bench SHALL cover reset asserted at cycle 3 of a divide -> busy=0, hi=lo=0 and no done pulse; then a new mult 6*7 after release -> lo=42 and hi=0.
